// File: rtl/mult_mode_counter.sv
// Multi-mode 4-bit game counter: counts up/down by 1 or 2, loads on demand,
// tallies visits to 0 and max, and pulses GAMEOVER with a WHO code.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   CONTROL_SIGNALS 00 up 1, 01 up 2, 10 down 1, 11 down 2
//   inital_value    value taken when INIT_SIGNAL is high
//   INIT_SIGNAL     synchronous load, wins over counting
//   counter         registered count
//   WHO             00 none, 01 winner, 10 loser (valid with GAMEOVER)
//   GAMEOVER        one-cycle end-of-game pulse
module mult_mode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       CONTROL_SIGNALS,
  input  logic [WIDTH-1:0] inital_value,
  input  logic             INIT_SIGNAL,
  output logic [WIDTH-1:0] counter,
  output logic [1:0]       WHO,
  output logic             GAMEOVER
);

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO =
    {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] MIN = '0;
  // Tally value one short of full: the next hit ends the game.
  localparam logic [WIDTH-1:0] LAST =
    {{(WIDTH-1){1'b1}}, 1'b0};

  mode_e            mode;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] winner_tally;
  logic [WIDTH-1:0] loser_tally;
  logic [WIDTH-1:0] win_nxt;
  logic [WIDTH-1:0] lose_nxt;
  logic [1:0]       who_nxt;
  logic             over_nxt;

  assign mode = mode_e'(CONTROL_SIGNALS);

  always_comb begin
    count_nxt = counter;
    if (INIT_SIGNAL) begin
      count_nxt = inital_value;
    end else begin
      unique case (mode)
        UP1: count_nxt = counter + ONE;
        UP2: count_nxt = counter + TWO;
        DN1: count_nxt = counter - ONE;
        DN2: count_nxt = counter - TWO;
        default: count_nxt = counter;
      endcase
    end
  end

  // Tallies look at the pre-edge counter, so a load cycle
  // still scores whatever value it is leaving.
  always_comb begin
    win_nxt  = winner_tally;
    lose_nxt = loser_tally;
    who_nxt  = 2'b00;
    over_nxt = 1'b0;
    if (counter == MAX) begin
      if (winner_tally == LAST) begin
        win_nxt  = '0;
        lose_nxt = '0;
        who_nxt  = 2'b01;
        over_nxt = 1'b1;
      end else begin
        win_nxt = winner_tally + ONE;
      end
    end else if (counter == MIN) begin
      if (loser_tally == LAST) begin
        win_nxt  = '0;
        lose_nxt = '0;
        who_nxt  = 2'b10;
        over_nxt = 1'b1;
      end else begin
        lose_nxt = loser_tally + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter      <= '0;
      winner_tally <= '0;
      loser_tally  <= '0;
      WHO          <= 2'b00;
      GAMEOVER     <= 1'b0;
    end else begin
      counter      <= count_nxt;
      winner_tally <= win_nxt;
      loser_tally  <= lose_nxt;
      WHO          <= who_nxt;
      GAMEOVER     <= over_nxt;
    end
  end

endmodule

// File: tb/tb_mult_mode_counter.sv
// Directed bench for mult_mode_counter: reset, load priority, all four
// count modes with wrap, game-over pulses and mid-game async reset.
module tb_mult_mode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] CONTROL_SIGNALS = 2'b00;
  logic [3:0] inital_value = 4'h0;
  logic       INIT_SIGNAL = 1'b0;
  logic [3:0] counter;
  logic [1:0] WHO;
  logic       GAMEOVER;

  int vectors = 0;
  int miscompares = 0;

  mult_mode_counter #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .CONTROL_SIGNALS(CONTROL_SIGNALS),
    .inital_value(inital_value),
    .INIT_SIGNAL(INIT_SIGNAL),
    .counter(counter),
    .WHO(WHO),
    .GAMEOVER(GAMEOVER)
  );

  always #5 clk = ~clk;

  // Reset, then perform one load edge of iv; returns 1ns after it.
  task automatic reset_load(input logic [3:0] iv,
                            input logic [1:0] mode);
    @(negedge clk);
    rst = 1'b0;
    INIT_SIGNAL = 1'b1;
    inital_value = iv;
    CONTROL_SIGNALS = mode;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    INIT_SIGNAL = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    inital_value = 4'hf;
    INIT_SIGNAL = 1'b0;
    CONTROL_SIGNALS = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({counter, WHO, GAMEOVER} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state got c=%0d who=%b go=%b want 0/00/0",
               counter, WHO, GAMEOVER);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (counter !== 4'(k)) begin
        miscompares++;
        $display("FAIL reset_release k=%0d got %0d want %0d",
                 k, counter, k);
      end
    end
  endtask

  task automatic test_load_up1;
    logic [3:0] e;
    reset_load(4'h0, 2'b00);
    INIT_SIGNAL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (counter !== 4'h0) begin
        miscompares++;
        $display("FAIL load_hold k=%0d got %0d want 0", k, counter);
      end
    end
    inital_value = 4'h2;
    @(posedge clk);
    #1;
    INIT_SIGNAL = 1'b0;
    vectors++;
    if (counter !== 4'h2) begin
      miscompares++;
      $display("FAIL load_two got %0d want 2", counter);
    end
    e = 4'h2;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      e = e + 4'd1;
      vectors++;
      if ({counter, WHO, GAMEOVER} !== {e, 3'b000}) begin
        miscompares++;
        $display("FAIL up1 k=%0d got c=%0d go=%b want c=%0d go=0",
                 k, counter, GAMEOVER, e);
      end
    end
  endtask

  // Run n edges from start, stepping exp by delta, expecting a
  // single game-over pulse with code who at edge go_k.
  task automatic run_game(input string name,
                          input logic [3:0] start,
                          input logic [3:0] delta,
                          input int n,
                          input int go_k,
                          input logic [1:0] who);
    logic [3:0] e;
    logic [1:0] ew;
    logic       eg;
    e = start;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      e = e + delta;
      eg = (k == go_k);
      ew = eg ? who : 2'b00;
      vectors++;
      if ({counter, WHO, GAMEOVER} !== {e, ew, eg}) begin
        miscompares++;
        $display("FAIL %s k=%0d got c=%0d who=%b go=%b want c=%0d who=%b go=%b",
                 name, k, counter, WHO, GAMEOVER, e, ew, eg);
      end
    end
  endtask

  task automatic test_down2_max;
    reset_load(4'hf, 2'b11);
    run_game("down2", 4'hf, 4'he, 130, 113, 2'b01);
  endtask

  task automatic test_down1_min;
    reset_load(4'h0, 2'b10);
    run_game("down1", 4'h0, 4'hf, 230, 209, 2'b10);
  endtask

  task automatic test_up2_odd_even;
    reset_load(4'h3, 2'b01);
    run_game("up2_odd", 4'h3, 4'h2, 125, 119, 2'b01);
    reset_load(4'h8, 2'b01);
    run_game("up2_even", 4'h8, 4'h2, 120, 109, 2'b10);
  endtask

  task automatic test_async_reset;
    reset_load(4'h0, 2'b10);
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (counter !== 4'h8) begin
      miscompares++;
      $display("FAIL pre_reset got %0d want 8", counter);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({counter, WHO, GAMEOVER} !== 7'b0) begin
      miscompares++;
      $display("FAIL async_clear got c=%0d who=%b go=%b want 0/00/0",
               counter, WHO, GAMEOVER);
    end
    INIT_SIGNAL = 1'b1;
    inital_value = 4'h8;
    CONTROL_SIGNALS = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    INIT_SIGNAL = 1'b0;
    run_game("post_reset", 4'h8, 4'h2, 115, 109, 2'b10);
  endtask

  initial begin
    test_reset();
    test_load_up1();
    test_down2_max();
    test_down1_min();
    test_up2_odd_even();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_mode_counter.md
Name: mult_mode_counter

Overview:
- 4-bit multi-mode game counter. It counts up or down by 1 or 2, selected by a 2-bit control input, and can be loaded synchronously with an initial value.
- Two internal 4-bit tallies record how often the counter sits at its minimum (0) or maximum (15).
- When either tally reaches 15, the block raises a one-cycle GAMEOVER pulse with a WHO code naming the winner, then restarts the tallies.
- Sits as a self-contained game/scoring engine driven by a controller that supplies the mode and load commands.

Parameters:
- WIDTH, 4, width of counter, inital_value and both tallies; all values below are for WIDTH=4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- CONTROL_SIGNALS  input  2  mode: 00 up by 1, 01 up by 2, 10 down by 1, 11 down by 2.
- inital_value  input  4  value loaded when INIT_SIGNAL=1.
- INIT_SIGNAL  input  1  synchronous load enable.
- counter  output  4  current registered counter value.
- WHO  output  2  game result: 00 none, 01 winner (max tally), 10 loser (min tally); 11 is never driven.
- GAMEOVER  output  1  one-cycle pulse marking the end of a game.

Behaviour:
- Reset (rst=0, asynchronous, overrides everything):
  - counter=0, WHO=00, GAMEOVER=0, winner_tally=0, loser_tally=0.
  - All inputs are ignored while reset is asserted.
  - Reset may arrive mid-game; all state clears immediately.
- Counter update, each rising edge with rst=1:
  - INIT_SIGNAL=1: counter <= inital_value. Load has priority over counting; CONTROL_SIGNALS is ignored.
  - Otherwise: counter <= counter ± step, per CONTROL_SIGNALS.
  - Arithmetic is modulo 16 (wrap, no saturation). Examples: 15+1=0, 15+2=1, 14+2=0, 0-1=15, 1-2=15, 0-2=14.
  - A mode change takes effect on the next edge with no pipeline latency.
- Tally update:
  - Evaluated each rising edge with rst=1, using the registered counter value before that edge (applies during load cycles too).
  - counter==15: winner_tally increments.
  - counter==0: loser_tally increments.
  - Both cannot happen on the same edge.
- Game over:
  - On the edge where an increment would bring winner_tally to 15: GAMEOVER<=1, WHO<=01, and both tallies clear to 0.
  - On the edge where an increment would bring loser_tally to 15: GAMEOVER<=1, WHO<=10, and both tallies clear to 0.
  - On every other edge: GAMEOVER<=0, WHO<=00. GAMEOVER and WHO are therefore registered and valid for exactly one cycle.
  - The counter is unaffected by game over; counting and loads continue uninterrupted.
  - A load on the game-over edge is honoured normally.
- Tallies are internal only, not ported.
- Outputs are fully registered; there are no combinational input-to-output paths.

Test Plan:
- Reset with junk inputs: hold rst=0, inital_value=1111, INIT_SIGNAL=0 -> counter=0, WHO=00, GAMEOVER=0. Release rst=1 with INIT_SIGNAL=0, mode 00 -> counter sequence 1,2,3...
- Load priority and up-by-1:
  - rst=1, INIT_SIGNAL=1, inital_value=0000, mode 00 for 4 edges -> counter stays 0 and loser_tally reaches 3-4.
  - Then load 0010 for one edge and release INIT -> counter 2,3,…,15,0,1,… with wrap 15->0.
- Down by 2 from max: load 1111, mode 11 -> sequence 15,13,11,9,7,5,3,1,15. After 15 visits to 15 -> single-cycle GAMEOVER=1 with WHO=01, then WHO=00 and tallies restart.
- Down by 1 from min: load 0000, mode 10 -> sequence 0,15,14,…,1,0. Tallies alternate; the first tally to reach 15 produces exactly one GAMEOVER pulse with the matching WHO code.
- Up by 2, odd vs even:
  - Load 0011, mode 01 -> 3,5,…,15,1,3; only winner_tally moves -> WHO=01.
  - Load 1000, mode 01 -> 8,10,12,14,0,2,…; only loser_tally moves -> WHO=10 after 15 visits to 0 (about 120 cycles).
- Asynchronous reset mid-game: assert rst=0 between clock edges with tallies nonzero -> counter, WHO, GAMEOVER clear immediately. After release, GAMEOVER requires a full 15 fresh visits.
